// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM port scheduler.
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StBusy
    } state_e;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Port-index width; never less than one bit so a single-port build still has an index.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-port wrapping address window: holds base/max/len and the current burst address.
module sdram_addr_gen #(
    parameter int unsigned ASIZE = 23,
    parameter int unsigned LSIZE = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [ASIZE-1:0] base_i,
    input  logic [ASIZE-1:0] max_i,
    input  logic [LSIZE-1:0] len_i,
    input  logic             adv_i,
    output logic [ASIZE-1:0] cur_addr_o,
    output logic [LSIZE-1:0] len_o
);

    logic [ASIZE-1:0] base_q, base_d;
    logic [ASIZE-1:0] max_q, max_d;
    logic [LSIZE-1:0] len_q, len_d;
    logic [ASIZE-1:0] cur_q, cur_d;
    logic [ASIZE:0]   sum;

    // Load beats advance; advance wraps to base once the next start would reach max.
    always_comb begin
        base_d = base_q;
        max_d  = max_q;
        len_d  = len_q;
        cur_d  = cur_q;
        sum    = {1'b0, cur_q} + (ASIZE + 1)'(len_q);
        if (load_i) begin
            base_d = base_i;
            max_d  = max_i;
            len_d  = len_i;
            cur_d  = base_i;
        end else if (adv_i) begin
            if (sum < {1'b0, max_q}) begin
                cur_d = sum[ASIZE-1:0];
            end else begin
                cur_d = base_q;
            end
        end
    end

    // Window registers; reset leaves the port disabled with an unbounded window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            max_q  <= '1;
            len_q  <= '0;
            cur_q  <= '0;
        end else begin
            base_q <= base_d;
            max_q  <= max_d;
            len_q  <= len_d;
            cur_q  <= cur_d;
        end
    end

    assign cur_addr_o = cur_q;
    assign len_o      = len_q;

endmodule

// File: rtl/sdram_port_scheduler.sv
// Burst scheduler: picks one eligible FIFO port and hands one burst to the command engine.
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int unsigned NWR      = 2,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ASIZE    = 23,
    parameter int unsigned LSIZE    = 9,
    parameter int unsigned USIZE    = 9,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [NWR+NRD-1:0]         port_load,
    input  logic [(NWR+NRD)*ASIZE-1:0] port_base,
    input  logic [(NWR+NRD)*ASIZE-1:0] port_max,
    input  logic [(NWR+NRD)*LSIZE-1:0] port_len,
    input  logic [NWR*USIZE-1:0]       wr_rdusedw,
    input  logic [NRD*USIZE-1:0]       rd_wrusedw,
    output logic                       req_valid,
    output logic                       req_write,
    output logic [ASIZE-1:0]           req_addr,
    output logic [LSIZE-1:0]           req_len,
    input  logic                       req_ack,
    input  logic                       xfer_done,
    output logic [NWR-1:0]             wr_sel,
    output logic [NRD-1:0]             rd_sel,
    output logic [NWR+NRD-1:0]         port_done
);

    localparam int unsigned NP = NWR + NRD;
    localparam int unsigned IW = clog2(NP);

    logic [ASIZE-1:0] cur_addr [NP];
    logic [LSIZE-1:0] len      [NP];
    logic [NP-1:0]    elig;
    logic [NP-1:0]    adv;

    state_e           state_q, state_d;
    logic             req_valid_q, req_valid_d;
    logic             req_write_q, req_write_d;
    logic [ASIZE-1:0] req_addr_q, req_addr_d;
    logic [LSIZE-1:0] req_len_q, req_len_d;
    logic [NP-1:0]    sel_q, sel_d;
    logic [NP-1:0]    port_done_q, port_done_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    int unsigned      slot;

    for (genvar p = 0; p < NP; p++) begin : g_port
        sdram_addr_gen #(
            .ASIZE (ASIZE),
            .LSIZE (LSIZE)
        ) u_addr_gen (
            .clk_i      (CLK),
            .rst_ni     (RESET_N),
            .load_i     (port_load[p]),
            .base_i     (port_base[p*ASIZE +: ASIZE]),
            .max_i      (port_max[p*ASIZE +: ASIZE]),
            .len_i      (port_len[p*LSIZE +: LSIZE]),
            .adv_i      (adv[p]),
            .cur_addr_o (cur_addr[p]),
            .len_o      (len[p])
        );

        assign adv[p] = (state_q == StBusy) && xfer_done && (grant_q == IW'(p));

        // Writes need a full burst waiting; reads need room for a full burst.
        if (p < NWR) begin : g_wr
            assign elig[p] = (len[p] != '0) &&
                             (32'(wr_rdusedw[p*USIZE +: USIZE]) >= 32'(len[p]));
        end else begin : g_rd
            assign elig[p] = (len[p] != '0) &&
                             (32'(rd_wrusedw[(p-NWR)*USIZE +: USIZE]) < 32'(len[p]));
        end
    end

    // Picker: scan from index 0 (fixed) or from rr_ptr with wrap (round-robin).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        slot       = 0;
        for (int unsigned i = 0; i < NP; i++) begin
            slot = (ARB_MODE == ARB_RR) ? ((32'(rr_ptr_q) + i) % NP) : i;
            if (!pick_found && elig[slot]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(slot);
            end
        end
    end

    // Next-state and next-output logic for the IDLE -> REQ -> BUSY handshake.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        port_done_d = '0;
        unique case (state_q)
            StIdle: begin
                // A window reload in flight blocks arbitration for that cycle.
                if (!(|port_load) && pick_found) begin
                    grant_d     = pick_idx;
                    req_valid_d = 1'b1;
                    req_write_d = (32'(pick_idx) < NWR);
                    req_addr_d  = cur_addr[pick_idx];
                    req_len_d   = len[pick_idx];
                    sel_d       = {{(NP-1){1'b0}}, 1'b1} << pick_idx;
                    rr_ptr_d    = (32'(pick_idx) == NP - 1) ? '0 : pick_idx + 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (req_ack) begin
                    req_valid_d = 1'b0;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (xfer_done) begin
                    port_done_d = sel_q;
                    sel_d       = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            sel_q       <= '0;
            port_done_q <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            sel_q       <= sel_d;
            port_done_q <= port_done_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_len   = req_len_q;
    assign wr_sel    = sel_q[NWR-1:0];
    assign rd_sel    = sel_q[NP-1:NWR];
    assign port_done = port_done_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Bench for sdram_port_scheduler: fixed-priority and round-robin instances share stimulus.
module tb_sdram_port_scheduler;

    logic        CLK;
    logic        RESET_N;
    logic [3:0]  port_load;
    logic [91:0] port_base;
    logic [91:0] port_max;
    logic [35:0] port_len;
    logic [17:0] wr_rdusedw;
    logic [17:0] rd_wrusedw;
    logic        req_ack;
    logic        xfer_done;

    logic        f_valid, f_write, r_valid, r_write;
    logic [22:0] f_addr, r_addr;
    logic [8:0]  f_len, r_len;
    logic [1:0]  f_wsel, f_rsel, r_wsel, r_rsel;
    logic [3:0]  f_done, r_done;

    logic        use_rr;
    logic        m_valid, m_write;
    logic [22:0] m_addr;
    logic [8:0]  m_len;
    logic [3:0]  m_sel, m_done;

    int checks;
    int failures;

    typedef struct {
        int          port;
        logic [22:0] addr;
        logic [8:0]  len;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [35:0] lens;
        logic [17:0] wlvl;
        logic [17:0] rlvl;
        int          exp_port;
    } vec_t;
    vec_t vecs[7];

    logic [22:0] cfg_base[4];
    logic [22:0] cfg_max[4];
    logic [8:0]  cfg_len[4];

    sdram_port_scheduler #(
        .NWR(2), .NRD(2), .ASIZE(23), .LSIZE(9), .USIZE(9), .ARB_MODE(0)
    ) u_fixed (
        .CLK(CLK), .RESET_N(RESET_N), .port_load(port_load), .port_base(port_base),
        .port_max(port_max), .port_len(port_len), .wr_rdusedw(wr_rdusedw),
        .rd_wrusedw(rd_wrusedw), .req_valid(f_valid), .req_write(f_write),
        .req_addr(f_addr), .req_len(f_len), .req_ack(req_ack), .xfer_done(xfer_done),
        .wr_sel(f_wsel), .rd_sel(f_rsel), .port_done(f_done)
    );

    sdram_port_scheduler #(
        .NWR(2), .NRD(2), .ASIZE(23), .LSIZE(9), .USIZE(9), .ARB_MODE(1)
    ) u_rr (
        .CLK(CLK), .RESET_N(RESET_N), .port_load(port_load), .port_base(port_base),
        .port_max(port_max), .port_len(port_len), .wr_rdusedw(wr_rdusedw),
        .rd_wrusedw(rd_wrusedw), .req_valid(r_valid), .req_write(r_write),
        .req_addr(r_addr), .req_len(r_len), .req_ack(req_ack), .xfer_done(xfer_done),
        .wr_sel(r_wsel), .rd_sel(r_rsel), .port_done(r_done)
    );

    assign m_valid = use_rr ? r_valid : f_valid;
    assign m_write = use_rr ? r_write : f_write;
    assign m_addr  = use_rr ? r_addr : f_addr;
    assign m_len   = use_rr ? r_len : f_len;
    assign m_sel   = use_rr ? {r_rsel, r_wsel} : {f_rsel, f_wsel};
    assign m_done  = use_rr ? r_done : f_done;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_f();
        return 64'({f_valid, f_write, f_addr, f_len, f_wsel, f_rsel, f_done});
    endfunction

    function automatic logic [63:0] outs_r();
        return 64'({r_valid, r_write, r_addr, r_len, r_wsel, r_rsel, r_done});
    endfunction

    task automatic do_reset();
        RESET_N    = 1'b0;
        port_load  = '0;
        req_ack    = 1'b0;
        xfer_done  = 1'b0;
        wr_rdusedw = '0;
        rd_wrusedw = '0;
        sb.delete();
        for (int p = 0; p < 4; p++) begin
            cfg_base[p] = 23'(p * 32'h10000);
            cfg_max[p]  = '1;
            cfg_len[p]  = '0;
        end
        repeat (2) step();
        RESET_N = 1'b1;
        step();
    endtask

    task automatic drive_cfg(input logic [3:0] mask);
        for (int p = 0; p < 4; p++) begin
            port_base[p*23 +: 23] = cfg_base[p];
            port_max[p*23 +: 23]  = cfg_max[p];
            port_len[p*9 +: 9]    = cfg_len[p];
        end
        port_load = mask;
    endtask

    task automatic load(input logic [3:0] mask);
        drive_cfg(mask);
        step();
        port_load = '0;
    endtask

    task automatic push(input int port, input logic [22:0] addr);
        exp_t e;
        e.port = port;
        e.addr = addr;
        e.len  = cfg_len[port];
        sb.push_back(e);
    endtask

    task automatic check_req(input exp_t e, input string tag);
        check({tag, "_write"}, 64'(m_write), 64'(e.port < 2));
        check({tag, "_addr"}, 64'(m_addr), 64'(e.addr));
        check({tag, "_len"}, 64'(m_len), 64'(e.len));
        check({tag, "_sel"}, 64'(m_sel), 64'(4'b0001 << e.port));
    endtask

    // Plays the command engine for one burst and scores it against the queue head.
    task automatic serve(input int ack_delay, input bit done_in_req, input bit load_at_done,
                         input bit drain, input bit abort_busy);
        exp_t e;
        int   waited;
        waited = 0;
        while (!m_valid && waited < 30) begin
            step();
            waited++;
        end
        if (!m_valid) begin
            check("req_timeout", 64'(m_valid), 64'(1));
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_req", 64'(sb.size()), 64'(1));
            return;
        end
        e = sb.pop_front();
        check_req(e, "grant");
        if (drain && e.port < 2) wr_rdusedw[e.port*9 +: 9] = '0;
        for (int i = 0; i < ack_delay; i++) begin
            xfer_done = done_in_req && (i == 1);
            step();
            check("hold_valid", 64'(m_valid), 64'(1));
            check_req(e, "hold");
            check("hold_no_done", 64'(m_done), 64'(0));
        end
        xfer_done = 1'b0;
        req_ack   = 1'b1;
        step();
        req_ack = 1'b0;
        check("valid_drop", 64'(m_valid), 64'(0));
        check("sel_busy", 64'(m_sel), 64'(4'b0001 << e.port));
        step();
        step();
        if (abort_busy) begin
            #2 RESET_N = 1'b0;
            #1;
            check("async_reset_f", outs_f(), 64'(0));
            check("async_reset_r", outs_r(), 64'(0));
            step();
            RESET_N = 1'b1;
            step();
            return;
        end
        xfer_done = 1'b1;
        if (load_at_done) begin
            cfg_base[e.port] = 23'h1000;
            drive_cfg(4'(1 << e.port));
        end
        step();
        xfer_done = 1'b0;
        port_load = '0;
        check("port_done", 64'(m_done), 64'(4'b0001 << e.port));
        check("sel_clear", 64'(m_sel), 64'(0));
        step();
        check("done_once", 64'(m_done), 64'(0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        use_rr   = 1'b0;
        // lens/levels are packed port-high-first: {p3,p2,p1,p0}, {w1,w0}, {r1,r0}
        vecs[0] = '{lens: {9'd256, 9'd256, 9'd256, 9'd256}, wlvl: {9'd0, 9'd256},
                    rlvl: {9'd256, 9'd0}, exp_port: 0};
        vecs[1] = '{lens: {9'd256, 9'd256, 9'd256, 9'd256}, wlvl: {9'd0, 9'd255},
                    rlvl: {9'd256, 9'd0}, exp_port: 2};
        vecs[2] = '{lens: '0, wlvl: '0, rlvl: '0, exp_port: -1};
        vecs[3] = '{lens: {9'd16, 9'd16, 9'd16, 9'd0}, wlvl: {9'd16, 9'd500},
                    rlvl: {9'd0, 9'd0}, exp_port: 1};
        vecs[4] = '{lens: {9'd16, 9'd0, 9'd16, 9'd16}, wlvl: {9'd0, 9'd0},
                    rlvl: {9'd15, 9'd0}, exp_port: 3};
        vecs[5] = '{lens: {9'd16, 9'd16, 9'd16, 9'd16}, wlvl: {9'd0, 9'd0},
                    rlvl: {9'd16, 9'd16}, exp_port: -1};
        vecs[6] = '{lens: {9'd8, 9'd8, 9'd8, 9'd8}, wlvl: {9'd8, 9'd0},
                    rlvl: {9'd0, 9'd0}, exp_port: 1};

        do_reset();
        check("reset_fixed", outs_f(), 64'(0));
        check("reset_rr", outs_r(), 64'(0));

        // Eligibility / fixed-priority table.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int p = 0; p < 4; p++) cfg_len[p] = vecs[v].lens[p*9 +: 9];
            wr_rdusedw = vecs[v].wlvl;
            rd_wrusedw = vecs[v].rlvl;
            if (vecs[v].exp_port >= 0) begin
                push(vecs[v].exp_port, cfg_base[vecs[v].exp_port]);
                load(4'hF);
                serve(0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                bit seen;
                seen = 1'b0;
                load(4'hF);
                repeat (12) begin
                    if (m_valid) seen = 1'b1;
                    step();
                end
                check("no_grant", 64'(seen), 64'(0));
            end
        end

        // Write p0 first, then read p2 once the write FIFO has drained.
        do_reset();
        for (int p = 0; p < 4; p++) cfg_len[p] = 9'd256;
        wr_rdusedw = {9'd0, 9'd256};
        rd_wrusedw = {9'd256, 9'd0};
        push(0, 23'h0);
        push(2, 23'h20000);
        load(4'hF);
        serve(0, 1'b0, 1'b0, 1'b1, 1'b0);
        serve(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Round-robin with every port eligible.
        use_rr = 1'b1;
        do_reset();
        for (int p = 0; p < 4; p++) cfg_len[p] = 9'd16;
        wr_rdusedw = {9'd16, 9'd16};
        rd_wrusedw = '0;
        push(0, 23'h0);
        push(1, 23'h10000);
        push(2, 23'h20000);
        push(3, 23'h30000);
        push(0, 23'h10);
        load(4'hF);
        repeat (5) serve(0, 1'b0, 1'b0, 1'b0, 1'b0);
        use_rr = 1'b0;

        // Wrap: 0 -> 256 -> 512 (512<640) -> 0 (768>=640).
        do_reset();
        cfg_base[0] = 23'h0;
        cfg_max[0]  = 23'd640;
        cfg_len[0]  = 9'd256;
        wr_rdusedw  = {9'd0, 9'd256};
        push(0, 23'd0);
        push(0, 23'd256);
        push(0, 23'd512);
        push(0, 23'd0);
        load(4'hF);
        repeat (4) serve(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reload of the granted port coinciding with completion: load wins.
        do_reset();
        cfg_base[0] = 23'h200;
        cfg_len[0]  = 9'd16;
        wr_rdusedw  = {9'd0, 9'd16};
        push(0, 23'h200);
        push(0, 23'h1000);
        load(4'hF);
        serve(0, 1'b0, 1'b1, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Slow ack with a stray xfer_done while still in REQ.
        do_reset();
        cfg_base[0] = 23'h40;
        cfg_len[0]  = 9'd16;
        wr_rdusedw  = {9'd0, 9'd16};
        push(0, 23'h40);
        load(4'hF);
        serve(5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while BUSY.
        do_reset();
        cfg_len[0] = 9'd16;
        wr_rdusedw = {9'd0, 9'd16};
        push(0, 23'h0);
        load(4'hF);
        serve(0, 1'b0, 1'b0, 1'b0, 1'b1);

        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
